// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that owns a single shared WIDTH-bit register.
// Each transaction runs IDLE -> WRITE -> ACK -> IDLE. The grant is held
// during WRITE. q loads on the WRITE->ACK edge and ack is held during ACK.
// Once a grant is issued, the write always completes unless reset arrives.
module dff_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic [CNT_W-1:0]      wr_count
);

    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    int                 j;

    // Find the first requester at or after ptr, wrapping around modulo NREQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    // Next-state and next-output logic; the grant and ack pulses default to 0
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = '0;
        ack_d   = '0;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    idx_d          = win_idx;
                    gnt_d[win_idx] = 1'b1;
                    state_d        = WRITE;
                end
            end
            WRITE: begin
                // The data slot is sampled even if the requester already dropped req
                data_d       = wdata[int'(idx_q)*WIDTH +: WIDTH];
                ack_d[idx_q] = 1'b1;
                state_d      = ACK;
            end
            ACK: begin
                ptr_d   = (idx_q == IDX_W'(NREQ-1)) ? '0 : idx_q + IDX_W'(1);
                cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset takes priority over any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign q        = data_q;
    assign busy     = busy_q;
    assign wr_count = cnt_q;

endmodule
